perip_cmd_master: RTL and testbench
===================================

PERIP_CMD_MASTER -- requirements
Module: perip_cmd_master

Interface
REQ-001 SHALL have parameter ADDR_A, default 5'h04: operand register address.
REQ-002 SHALL have parameter ADDR_INIT, default 5'h0C: start/init register address.
REQ-003 SHALL have parameter ADDR_DONE, default 5'h10: done-status register address.
REQ-004 SHALL have parameter ADDR_DATA, default 5'h14: result register address.
REQ-005 SHALL have parameter MAX_POLLS, default 255: done-poll limit, used only with POLL_TIMEOUT_EN.
REQ-006 SHALL have clk  input  1  single clock; all logic on its rising edge.
REQ-007 SHALL have reset  input  1  synchronous, active-high reset.
REQ-008 SHALL have req  input  1  start one transaction; sampled only in IDLE.
REQ-009 SHALL have operand  input  16  value written to ADDR_A; captured when req is accepted.
REQ-010 SHALL have busy  output  1  high in every state except IDLE.
REQ-011 SHALL have resp_valid  output  1  one-cycle pulse; result and error are valid in that cycle.
REQ-012 SHALL have result  output  32  captured peripheral result; held until the next capture.
REQ-013 SHALL have error  output  1  timeout flag; valid with resp_valid.
REQ-014 SHALL have cs, rd, wr  output  1 each  peripheral bus strobes.
REQ-015 SHALL have addr  output  5  peripheral register address.
REQ-016 SHALL have p_d_in  output  16  write data to peripheral d_in.
REQ-017 SHALL have p_d_out  input  32  read data from peripheral d_out.

Function
REQ-018 SHALL implement states IDLE, WR_A, GAP_A, WR_INIT, GAP_I, RD_DONE, CHK_DONE, RD_DATA, CAP_DATA, RESP.
REQ-019 State transitions SHALL be: IDLE->WR_A on req; WR_A->GAP_A->WR_INIT->GAP_I->RD_DONE->CHK_DONE; CHK_DONE->RD_DATA if p_d_out[0]=1, otherwise ->RD_DONE; RD_DATA->CAP_DATA->RESP->IDLE.
REQ-020 Each access SHALL be a single strobe cycle followed by at least one cycle with cs=rd=wr=0.
REQ-021 WR_A SHALL drive cs=1, wr=1, rd=0, addr=ADDR_A, p_d_in=captured operand.
REQ-022 WR_INIT SHALL drive cs=1, wr=1, rd=0, addr=ADDR_INIT, p_d_in=16'h0001.
REQ-023 RD_DONE SHALL drive cs=1, rd=1, wr=0, addr=ADDR_DONE; RD_DATA SHALL drive the same with addr=ADDR_DATA.
REQ-024 Read data SHALL be sampled in the cycle after the strobe (CHK_DONE, CAP_DATA), which tolerates a registered peripheral d_out.
REQ-025 Outside strobe states: cs=rd=wr=0, addr=0, p_d_in=0.
REQ-026 Minimum latency SHALL be 9 cycles from the req-accept edge to resp_valid; each extra poll SHALL add 2 cycles.
REQ-027 In RESP: resp_valid=1; error=0 on normal completion.
REQ-028 req outside IDLE, including in RESP, SHALL be ignored and not queued.
REQ-029 operand changes after acceptance SHALL not affect the transaction in progress.

Reset
REQ-030 When reset=1, the next state SHALL be IDLE, with busy=0, resp_valid=0, error=0, result=0, cs=rd=wr=0, addr=0, p_d_in=0, and the poll counter=0.
REQ-031 Reset SHALL override req in the same cycle.
REQ-032 Reset mid-transaction SHALL abort it with no resp_valid; the next req SHALL restart from WR_A.

Configuration
REQ-033 The macro POLL_TIMEOUT_EN SHALL enable an 8-bit poll counter, cleared on req acceptance and incremented each RD_DONE.
REQ-034 With POLL_TIMEOUT_EN: CHK_DONE with done=0 and counter=MAX_POLLS SHALL go to RESP with error=1 and result unchanged.
REQ-035 Without POLL_TIMEOUT_EN: no counter; polling is unbounded; error is tied to 0.

Verification
REQ-036 operand=16'h0441, peripheral done on first poll, data=32'h21 -> bus sequence wr@04(0441), wr@0C(0001), rd@10, rd@14; resp_valid 9 cycles after req; result=32'h00000021; error=0.
REQ-037 done=0 for 3 polls then 1 -> four RD_DONE strobes; resp_valid at cycle 15.
REQ-038 req pulsed during GAP_I and during RESP -> no second transaction; busy drops one cycle after RESP.
REQ-039 reset asserted in CHK_DONE -> all outputs 0 next cycle; no resp_valid; a new req for 16'h0010 completes with result 32'h4.
REQ-040 POLL_TIMEOUT_EN, MAX_POLLS=4, done stuck 0 -> exactly 4 RD_DONE strobes; resp_valid with error=1; no RD_DATA strobe.
REQ-041 Without the macro, done stuck 0 for 300 polls -> still polling, busy=1, error=0.

Source files
------------

// File: rtl/perip_cmd_master.sv
// Command master for a simple register peripheral: it writes the operand, starts the peripheral, polls done and reads the result.
// Optional POLL_TIMEOUT_EN bounds the done-polling at MAX_POLLS and reports a timeout through error.
module perip_cmd_master #(
  parameter logic [4:0] ADDR_A    = 5'h04,
  parameter logic [4:0] ADDR_INIT = 5'h0C,
  parameter logic [4:0] ADDR_DONE = 5'h10,
  parameter logic [4:0] ADDR_DATA = 5'h14,
  parameter int         MAX_POLLS = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic [15:0] operand,
  output logic        busy,
  output logic        resp_valid,
  output logic [31:0] result,
  output logic        error,
  output logic        cs,
  output logic        rd,
  output logic        wr,
  output logic [4:0]  addr,
  output logic [15:0] p_d_in,
  input  logic [31:0] p_d_out,
  output logic [3:0]  dbg_state
);

  // Handshake: req is accepted only while busy is low (IDLE) and is never queued;
  // resp_valid is a one-cycle pulse with result/error valid in that cycle, no backpressure.
  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    WR_A     = 4'd1,
    GAP_A    = 4'd2,
    WR_INIT  = 4'd3,
    GAP_I    = 4'd4,
    RD_DONE  = 4'd5,
    CHK_DONE = 4'd6,
    RD_DATA  = 4'd7,
    CAP_DATA = 4'd8,
    RESP     = 4'd9
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [15:0] op_q;
  logic        accept;
  logic        timeout;
  logic        err_q;

  assign accept = (state == IDLE) && req;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      op_q   <= 16'h0000;
      result <= 32'h0000_0000;
    end else begin
      state <= state_nx;
      if (accept) begin
        op_q <= operand;
      end
      // Read data arrives one cycle after the RD_DATA strobe.
      if (state == CAP_DATA) begin
        result <= p_d_out;
      end
    end
  end

`ifdef POLL_TIMEOUT_EN
  localparam logic [7:0] MAX_POLLS_8 = 8'(MAX_POLLS);

  logic [7:0] poll_cnt;

  assign timeout = (poll_cnt == MAX_POLLS_8);

  always_ff @(posedge clk) begin
    if (reset) begin
      poll_cnt <= 8'h00;
      err_q    <= 1'b0;
    end else if (accept) begin
      poll_cnt <= 8'h00;
      err_q    <= 1'b0;
    end else begin
      if (state == RD_DONE) begin
        poll_cnt <= poll_cnt + 8'h01;
      end
      if ((state == CHK_DONE) && !p_d_out[0] && timeout) begin
        err_q <= 1'b1;
      end
    end
  end
`else
  assign timeout = 1'b0;
  assign err_q   = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    cs       = 1'b0;
    rd       = 1'b0;
    wr       = 1'b0;
    addr     = 5'h00;
    p_d_in   = 16'h0000;
    case (state)
      IDLE: begin
        if (req) begin
          state_nx = WR_A;
        end
      end
      WR_A: begin
        cs       = 1'b1;
        wr       = 1'b1;
        addr     = ADDR_A;
        p_d_in   = op_q;
        state_nx = GAP_A;
      end
      GAP_A: begin
        state_nx = WR_INIT;
      end
      WR_INIT: begin
        cs       = 1'b1;
        wr       = 1'b1;
        addr     = ADDR_INIT;
        p_d_in   = 16'h0001;
        state_nx = GAP_I;
      end
      GAP_I: begin
        state_nx = RD_DONE;
      end
      RD_DONE: begin
        cs       = 1'b1;
        rd       = 1'b1;
        addr     = ADDR_DONE;
        state_nx = CHK_DONE;
      end
      CHK_DONE: begin
        // Done status is sampled here, one cycle after the RD_DONE strobe.
        if (p_d_out[0]) begin
          state_nx = RD_DATA;
        end else if (timeout) begin
          state_nx = RESP;
        end else begin
          state_nx = RD_DONE;
        end
      end
      RD_DATA: begin
        cs       = 1'b1;
        rd       = 1'b1;
        addr     = ADDR_DATA;
        state_nx = CAP_DATA;
      end
      CAP_DATA: begin
        state_nx = RESP;
      end
      RESP: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  assign busy       = (state != IDLE);
  assign resp_valid = (state == RESP);
  assign error      = resp_valid && err_q;
  assign dbg_state  = state;

endmodule

// File: tb/tb_perip_cmd_master.sv
// Bench for perip_cmd_master: a scripted register peripheral plus a transaction-level model of the expected bus traffic and response.
// Build with +define+POLL_TIMEOUT_EN to exercise the bounded-poll variant (MAX_POLLS=4).
module tb_perip_cmd_master;

  localparam logic [4:0] ADDR_A    = 5'h04;
  localparam logic [4:0] ADDR_INIT = 5'h0C;
  localparam logic [4:0] ADDR_DONE = 5'h10;
  localparam logic [4:0] ADDR_DATA = 5'h14;
`ifdef POLL_TIMEOUT_EN
  localparam int MAXP = 4;
`else
  localparam int MAXP = 255;
`endif
  localparam int W = 23;

  logic        clk;
  logic        reset;
  logic        req;
  logic [15:0] operand;
  logic        busy;
  logic        resp_valid;
  logic [31:0] result;
  logic        error;
  logic        cs;
  logic        rd;
  logic        wr;
  logic [4:0]  addr;
  logic [15:0] p_d_in;
  logic [31:0] p_d_out;
  logic [3:0]  dbg_state;

  perip_cmd_master #(
    .ADDR_A(ADDR_A), .ADDR_INIT(ADDR_INIT), .ADDR_DONE(ADDR_DONE),
    .ADDR_DATA(ADDR_DATA), .MAX_POLLS(MAXP)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .operand(operand),
    .busy(busy), .resp_valid(resp_valid), .result(result), .error(error),
    .cs(cs), .rd(rd), .wr(wr), .addr(addr), .p_d_in(p_d_in),
    .p_d_out(p_d_out), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] acc(input bit w, input bit r, input logic [4:0] a,
                                       input logic [15:0] d);
    return {w, r, a, d};
  endfunction

  logic [W-1:0] exp_q[$];

  // ---------------- peripheral model (registered d_out) ----------------
  int          zeros_cfg  = 0;
  logic [31:0] data_cfg   = 32'h0;
  int          polls_seen = 0;
  logic        rd_pend    = 1'b0;
  logic [4:0]  rd_addr    = 5'h0;
  logic        init_seen  = 1'b0;
  logic        prev_cs    = 1'b0;

  initial p_d_out = 32'h0;

  always @(posedge clk) begin
    if (init_seen) polls_seen <= 0;
    if (rd_pend) begin
      if (rd_addr == ADDR_DONE) begin
        p_d_out    <= (polls_seen >= zeros_cfg) ? 32'h1 : (32'($urandom()) & 32'hFFFF_FFFE);
        polls_seen <= polls_seen + 1;
      end else begin
        p_d_out <= data_cfg;
      end
    end
  end

  // Bus monitor / scoreboard, sampled mid-cycle.
  always @(negedge clk) begin
    logic [W-1:0] got;
    got = {wr, rd, addr, p_d_in};
    if (cs) begin
      check("strobe_gap", 64'(prev_cs), 64'd0);
      if (exp_q.size() == 0) check("bus_unexpected", 64'(got), 64'd0);
      else check("bus_access", 64'(got), 64'(exp_q.pop_front()));
    end else begin
      check("idle_bus", 64'(got), 64'd0);
    end
    prev_cs   = cs;
    rd_pend   = cs && rd;
    rd_addr   = addr;
    init_seen = cs && wr && (addr == ADDR_INIT);
  end

  // ---------------- driver tasks ----------------
  logic [31:0] model_result = 32'h0;

  task automatic run_txn(input logic [15:0] op, input int zeros, input logic [31:0] data,
                         input bit glitch);
    int          npolls;
    bit          tmo;
    int          exp_lat;
    int          n;
    logic [31:0] exp_res;
`ifdef POLL_TIMEOUT_EN
    tmo = (zeros >= MAXP);
`else
    tmo = 1'b0;
`endif
    npolls  = tmo ? MAXP : zeros + 1;
    exp_lat = 4 + 2 * npolls + (tmo ? 1 : 3);
    exp_res = tmo ? model_result : data;
    exp_q.push_back(acc(1, 0, ADDR_A, op));
    exp_q.push_back(acc(1, 0, ADDR_INIT, 16'h0001));
    for (int i = 0; i < npolls; i++) exp_q.push_back(acc(0, 1, ADDR_DONE, 16'h0));
    if (!tmo) exp_q.push_back(acc(0, 1, ADDR_DATA, 16'h0));
    zeros_cfg = zeros;
    data_cfg  = data;

    @(negedge clk);
    req     = 1'b1;
    operand = op;
    @(posedge clk);
    #1;
    n       = 1;
    req     = 1'b0;
    operand = 16'($urandom());
    check("busy_after_accept", 64'(busy), 64'd1);
    while (!resp_valid && n < 700) begin
      req = (glitch && n == 4);
      @(posedge clk);
      #1;
      n++;
    end
    check("resp_seen", 64'(resp_valid), 64'd1);
    check("latency", 64'(n), 64'(exp_lat));
    check("result", 64'(result), 64'(exp_res));
    check("error", 64'(error), 64'(tmo));
    if (glitch) req = 1'b1;
    @(posedge clk);
    #1;
    req = 1'b0;
    check("busy_after_resp", 64'(busy), 64'd0);
    check("resp_pulse", 64'(resp_valid), 64'd0);
    if (glitch) begin
      @(posedge clk);
      #1;
      check("req_not_queued", 64'(busy), 64'd0);
    end
    check("bus_drain", 64'(exp_q.size()), 64'd0);
    model_result = exp_res;
  endtask

  function automatic logic [63:0] all_outputs();
    return 64'({busy, resp_valid, error, cs, rd, wr, addr, p_d_in, result});
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int n;
    reset   = 1'b1;
    req     = 1'b1;
    operand = 16'hBEEF;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", all_outputs(), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    req   = 1'b0;
    @(posedge clk);
    #1;
    check("idle_after_reset", 64'(busy), 64'd0);

    run_txn(16'h0441, 0, 32'h0000_0021, 1'b0);
    run_txn(16'($urandom()), 3, 32'($urandom()), 1'b0);
    run_txn(16'($urandom()), 1, 32'($urandom()), 1'b1);

    // Abort in CHK_DONE, then restart cleanly.
    zeros_cfg = 5;
    data_cfg  = 32'h4;
    exp_q.push_back(acc(1, 0, ADDR_A, 16'h0010));
    exp_q.push_back(acc(1, 0, ADDR_INIT, 16'h0001));
    exp_q.push_back(acc(0, 1, ADDR_DONE, 16'h0));
    @(negedge clk);
    req     = 1'b1;
    operand = 16'h0010;
    @(posedge clk);
    #1;
    req = 1'b0;
    n   = 1;
    while (n < 6) begin
      @(posedge clk);
      #1;
      n++;
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("abort_outputs", all_outputs(), 64'd0);
    check("abort_drain", 64'(exp_q.size()), 64'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("abort_no_resp", 64'(resp_valid | busy), 64'd0);
    model_result = 32'h0;
    run_txn(16'h0010, 0, 32'h4, 1'b0);

    for (int t = 0; t < 12; t++) begin
      run_txn(16'($urandom()), int'($urandom_range(0, 3)), 32'($urandom()),
              1'($urandom_range(0, 1)));
    end

`ifdef POLL_TIMEOUT_EN
    run_txn(16'($urandom()), 100000, 32'($urandom()), 1'b0);
    run_txn(16'($urandom()), 2, 32'($urandom()), 1'b0);
`else
    // Done never asserts: polling must stay unbounded.
    zeros_cfg = 100000;
    exp_q.push_back(acc(1, 0, ADDR_A, 16'h1234));
    exp_q.push_back(acc(1, 0, ADDR_INIT, 16'h0001));
    for (int i = 0; i < 300; i++) exp_q.push_back(acc(0, 1, ADDR_DONE, 16'h0));
    @(negedge clk);
    req     = 1'b1;
    operand = 16'h1234;
    @(posedge clk);
    #1;
    req = 1'b0;
    n   = 0;
    while (exp_q.size() != 0 && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("long_poll_consumed", 64'(exp_q.size()), 64'd0);
    check("long_poll_busy", 64'(busy), 64'd1);
    check("long_poll_no_resp", 64'({resp_valid, error}), 64'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("long_poll_abort", all_outputs(), 64'd0);
    model_result = 32'h0;
    run_txn(16'($urandom()), 2, 32'($urandom()), 1'b0);
`endif

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
